aucohl_fifo_th: RTL
===================

Name: aucohl_fifo_th

Overview:
- Parametrised synchronous FIFO; next-generation replacement for the library's fixed 16-entry FIFO.
- Adds a full-range level count, a programmable threshold flag, synchronous flush, and sticky overflow/underflow error flags.
- Sits between bus-side register logic and serial engines (UART/SPI TX/RX buffers). Its threshold flag feeds the interrupt logic directly.

Parameters:
- DW, 8, data width in bits (>=1).
- AW, 4, address width (>=1); DEPTH = 2**AW entries.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents and error flags.
- wr  input  1  write request.
- wdata  input  DW  write data.
- rd  input  1  read request; pops the entry currently on rdata.
- rdata  output  DW  head-of-queue data (first-word fall-through).
- empty  output  1  no entries stored.
- full  output  1  DEPTH entries stored.
- level  output  AW+1  number of stored entries, 0..DEPTH.
- threshold  input  AW+1  level compare value.
- th_reached  output  1  high when level > threshold.
- overflow  output  1  sticky: a write was attempted while full and not accepted.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers = 0, level = 0, empty = 1, full = 0.
  - th_reached = 0 until the first level update; the flag is recomputed from the registered level.
  - overflow = underflow = 0.
  - Storage array is not reset; rdata is undefined while empty.
- Storage: DEPTH x DW register array. Write and read pointers are AW bits and wrap modulo DEPTH.
- Acceptance, evaluated each posedge:
  - Write accepted when wr & (~full | rd).
  - Read accepted when rd & ~empty.
- Accepted write: array[w_ptr] <= wdata; w_ptr += 1.
- Accepted read: r_ptr += 1. rdata = array[r_ptr], combinational from the registered pointer; no read latency.
- Level update: level += (write accepted) - (read accepted). empty and full are registered and derived from the next level (0 and DEPTH respectively).
- Latency: a write at edge N is visible on rdata/empty from edge N onward, i.e. readable in the cycle after the write.
- Simultaneous wr & rd:
  - Empty: write accepted, read ignored, underflow set; level 0 -> 1.
  - Full: both accepted; the head is popped and the new word is stored in the freed slot; level stays DEPTH and full stays 1.
  - Otherwise: both accepted, level unchanged.
- Error flags:
  - overflow sets when wr & full & ~rd.
  - underflow sets when rd & empty.
  - Both are sticky; cleared only by flush or reset.
- Flush, synchronous and highest priority:
  - Pointers = 0, level = 0, empty = 1, full = 0, overflow = underflow = 0.
  - wr/rd in the same cycle are ignored and do not set error flags.
- th_reached: registered, equal to (next level > threshold) each cycle; also recomputed when threshold changes.
  - threshold >= DEPTH gives th_reached permanently 0.
  - threshold = 0 gives th_reached = ~empty, registered.
- Arithmetic: level and threshold are unsigned AW+1 bits. Pointer increments wrap naturally at 2**AW.
- No X propagation on control outputs for any wr/rd/flush combination after reset.

Test Plan (DW=8, AW=4, DEPTH=16):
- Reset, then fill: write 0x00..0x0F on 16 consecutive cycles -> level steps 1..16; full=1 after the 16th edge; empty=0; overflow=0.
- Overflow: with FIFO full, wr=1 rd=0 with 0xAA -> overflow=1, level stays 16. Read all 16 -> data 0x00..0x0F in order, 0xAA never appears.
- Full simultaneous: with FIFO full, wr=1 rd=1 with 0x55 -> rdata advances by one, level=16, full=1, overflow=0. After draining, 0x55 is the last word out.
- Empty simultaneous and underflow: on an empty FIFO, rd=1 alone -> underflow=1, level=0. Next, wr=1 rd=1 with 0x3C -> level=1, rdata=0x3C, underflow stays 1.
- Wrap and threshold: threshold=4; write 20 / read 20 interleaved so the pointers wrap -> data order preserved across the wrap. th_reached=1 exactly when level goes 4->5 and 0 when it returns to 4.
- Flush and reset mid-operation:
  - Level=7, overflow=1, then pulse flush together with wr=1 -> level=0, empty=1, overflow=0, write dropped.
  - Assert rst_n=0 asynchronously between edges with level=3 -> level=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aucohl_fifo_th_if.sv
// FIFO bus bundle: master drives write/read/flush/threshold and the FIFO (slave)
// returns head data, level, the threshold flag and the sticky error flags.
interface aucohl_fifo_th_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          flush;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          rd;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic [AW:0]   threshold;
  logic          th_reached;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wr, wdata, rd, threshold,
    input  rdata, empty, full, level, th_reached, overflow, underflow
  );

  modport slave (
    input  flush, wr, wdata, rd, threshold,
    output rdata, empty, full, level, th_reached, overflow, underflow
  );
endinterface

// File: rtl/aucohl_fifo_th.sv
// Parametrised FWFT FIFO with level count, threshold flag, flush and sticky errors.
// Write visible on rdata the cycle after it lands; writes while full are dropped unless a read frees a slot.
module aucohl_fifo_th #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aucohl_fifo_th_if.slave   bus
);
  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_nxt;
  logic          empty_q;
  logic          full_q;
  logic          th_q;
  logic          ovf_q;
  logic          udf_q;
  logic          wr_acc;
  logic          rd_acc;

  // A read while full frees the head slot, so the write may land in the same edge.
  always_comb begin
    wr_acc    = bus.wr & (~full_q | bus.rd);
    rd_acc    = bus.rd & ~empty_q;
    level_nxt = level_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.flush) begin
      mem[w_ptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      th_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.flush) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      th_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      level_q <= level_nxt;
      empty_q <= (level_nxt == '0);
      full_q  <= (level_nxt == LVL_FULL);
      th_q    <= (level_nxt > bus.threshold);
      if (bus.wr && full_q && !bus.rd) ovf_q <= 1'b1;
      if (bus.rd && empty_q)           udf_q <= 1'b1;
    end
  end

  assign bus.rdata      = mem[r_ptr];
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.level      = level_q;
  assign bus.th_reached = th_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
endmodule
